param_printer: RTL and testbench

PARAM_PRINTER -- requirements
Module: param_printer

---
 rtl/param_printer_pkg.sv | 43 ++++
 rtl/param_printer_div10.sv | 59 +++++
 rtl/param_printer.sv | 146 ++++++++++++++
 tb/tb_param_printer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/param_printer_pkg.sv
// rtl/param_printer_pkg.sv - shared states, ASCII constants and prefix lookup for param_printer
package param_printer_pkg;

    localparam int DIGITS = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_PREFIX,
        S_DIGITS,
        S_NEWLINE,
        S_DONE
    } state_t;

    localparam logic [7:0] ASCII_V     = 8'h56;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_L     = 8'h4C;
    localparam logic [7:0] ASCII_U     = 8'h55;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_UNDER = 8'h5F;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_1     = 8'h31;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_DIGIT = 8'h30;

    // "VALUE_n=" by index; sel picks which value's index digit appears at position 6
    function automatic logic [7:0] prefix_char(input logic [2:0] idx, input logic sel);
        logic [7:0] c;
        case (idx)
            3'd0:    c = ASCII_V;
            3'd1:    c = ASCII_A;
            3'd2:    c = ASCII_L;
            3'd3:    c = ASCII_U;
            3'd4:    c = ASCII_E;
            3'd5:    c = ASCII_UNDER;
            3'd6:    c = sel ? ASCII_1 : ASCII_0;
            default: c = ASCII_EQ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/param_printer_div10.sv
// rtl/param_printer_div10.sv - sequential restoring divide-by-10, one quotient bit per cycle
module div10_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    output logic [WIDTH-1:0] quotient,
    output logic [3:0]       remainder,
    output logic             done
);

    logic [5:0]       count;
    logic             active;
    logic [WIDTH-1:0] cur_q;
    logic [WIDTH-1:0] next_q;
    logic [3:0]       cur_r;
    logic [3:0]       next_r;
    logic [4:0]       trial;
    logic             fits;

    // The start cycle already performs the first step, so a run takes exactly WIDTH edges
    always_comb begin
        cur_q  = start ? dividend : quotient;
        cur_r  = start ? 4'd0 : remainder;
        trial  = {cur_r, cur_q[WIDTH-1]};
        fits   = (trial >= 5'd10);
        next_r = fits ? 4'(trial - 5'd10) : trial[3:0];
        next_q = (cur_q << 1) | WIDTH'(fits);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            count     <= '0;
            active    <= 1'b0;
            done      <= 1'b0;
        end else if (start) begin
            quotient  <= next_q;
            remainder <= next_r;
            count     <= 6'(WIDTH - 1);
            active    <= (WIDTH > 1);
            done      <= (WIDTH == 1);
        end else if (active) begin
            quotient  <= next_q;
            remainder <= next_r;
            count     <= count - 6'd1;
            if (count == 6'd1) begin
                active <= 1'b0;
                done   <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/param_printer.sv
// rtl/param_printer.sv - streams "VALUE_0=<d0>\nVALUE_1=<d1>\n" as ASCII bytes over a valid/ready port
module param_printer
    import param_printer_pkg::*;
#(
    parameter logic [31:0] VALUE_0 = 32'd5,
    parameter logic [31:0] VALUE_1 = 32'd9,
    parameter int          WIDTH   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    state_t           state;
    logic             sel;
    logic [2:0]       pidx;
    logic [3:0]       ndig;
    logic [3:0]       didx;
    logic [3:0]       digit_buf [DIGITS];

    logic             div_start;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_quot;
    logic [3:0]       div_rem;
    logic             div_done;
    logic             xfer;

    assign xfer = tx_valid && tx_ready;

    // Divider restarts on the same edge a digit is captured so each digit costs exactly WIDTH cycles
    always_comb begin
        div_start    = 1'b0;
        div_dividend = div_quot;
        case (state)
            S_IDLE: begin
                div_start    = start;
                div_dividend = VALUE_0[WIDTH-1:0];
            end
            S_CONV: begin
                div_start = div_done && (div_quot != '0);
            end
            S_NEWLINE: begin
                div_start    = xfer && !sel;
                div_dividend = VALUE_1[WIDTH-1:0];
            end
            default: ;
        endcase
    end

    div10_seq #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (div_dividend),
        .quotient  (div_quot),
        .remainder (div_rem),
        .done      (div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sel      <= 1'b0;
            pidx     <= '0;
            ndig     <= '0;
            didx     <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < DIGITS; i++) digit_buf[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CONV;
                        sel   <= 1'b0;
                        ndig  <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (div_done) begin
                        if (ndig < 4'(DIGITS)) digit_buf[ndig] <= div_rem;
                        ndig <= ndig + 4'd1;
                        if (div_quot == '0) begin
                            state    <= S_PREFIX;
                            pidx     <= '0;
                            tx_data  <= prefix_char(3'd0, sel);
                            tx_valid <= 1'b1;
                        end
                    end
                end
                S_PREFIX: begin
                    if (xfer) begin
                        if (pidx == 3'd7) begin
                            state   <= S_DIGITS;
                            didx    <= ndig - 4'd1;
                            tx_data <= ASCII_DIGIT + {4'd0, digit_buf[ndig - 4'd1]};
                        end else begin
                            pidx    <= pidx + 3'd1;
                            tx_data <= prefix_char(pidx + 3'd1, sel);
                        end
                    end
                end
                S_DIGITS: begin
                    // Digits were stored least significant first, so walk the buffer downwards
                    if (xfer) begin
                        if (didx == 4'd0) begin
                            state   <= S_NEWLINE;
                            tx_data <= ASCII_LF;
                        end else begin
                            didx    <= didx - 4'd1;
                            tx_data <= ASCII_DIGIT + {4'd0, digit_buf[didx - 4'd1]};
                        end
                    end
                end
                S_NEWLINE: begin
                    if (xfer) begin
                        tx_valid <= 1'b0;
                        if (!sel) begin
                            state <= S_CONV;
                            sel   <= 1'b1;
                            ndig  <= '0;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_printer.sv
// tb/tb_param_printer.sv - directed bench for param_printer across four parameter sets
module tb_param_printer;

    localparam logic [127:0] V0S = {32'd15, 32'd0, 32'd32, 32'd5};
    localparam logic [127:0] V1S = {32'd0, 32'hFFFF_FFFF, 32'd33, 32'd9};
    localparam logic [127:0] WS  = {32'd4, 32'd32, 32'd32, 32'd32};

    localparam string EXP0 = "VALUE_0=5\nVALUE_1=9\n";
    localparam string EXP1 = "VALUE_0=32\nVALUE_1=33\n";
    localparam string EXP2 = "VALUE_0=0\nVALUE_1=4294967295\n";
    localparam string EXP3 = "VALUE_0=15\nVALUE_1=0\n";

    logic       clk = 1'b0;
    logic [3:0] rst;
    logic [3:0] start;
    logic [3:0] ready;
    logic [3:0] valid;
    logic [3:0] busy;
    logic [3:0] done;
    logic [7:0] data [4];

    string rx [4];
    int    done_cnt [4];
    int    stall_cnt [4];
    int    stall_errs [4];
    bit    prev_stall [4];
    logic [7:0] prev_data [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        param_printer #(
            .VALUE_0 (V0S[g*32 +: 32]),
            .VALUE_1 (V1S[g*32 +: 32]),
            .WIDTH   (int'(WS[g*32 +: 32]))
        ) dut (
            .clk      (clk),
            .rst      (rst[g]),
            .start    (start[g]),
            .tx_data  (data[g]),
            .tx_valid (valid[g]),
            .tx_ready (ready[g]),
            .busy     (busy[g]),
            .done     (done[g])
        );
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst[i]) begin
                if (prev_stall[i] && !(valid[i] && data[i] == prev_data[i])) stall_errs[i] <= stall_errs[i] + 1;
                if (valid[i] && !ready[i]) stall_cnt[i] <= stall_cnt[i] + 1;
                if (valid[i] && ready[i]) rx[i] <= $sformatf("%s%c", rx[i], data[i]);
                if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
            end
            prev_stall[i] <= valid[i] && !ready[i] && !rst[i];
            prev_data[i]  <= data[i];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic string vis(input string s);
        string r = "";
        for (int k = 0; k < s.len(); k++) r = (s[k] == 8'h0A) ? {r, "|"} : {r, s.substr(k, k)};
        return r;
    endfunction

    function automatic string tail(input int i, input int from);
        return (rx[i].len() > from) ? rx[i].substr(from, rx[i].len() - 1) : "";
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int max_cyc, output bit seen, output logic busy_at);
        seen = 1'b0;
        busy_at = 1'bx;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (done[i]) begin
                seen = 1'b1;
                busy_at = busy[i];
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 4'hF; start = 4'b0010; ready = 4'hF;
        repeat (3) tick();
        rst = 4'h0; start = 4'h0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (valid[i] !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d]: got %b want 0", i, valid[i]); end
            n_cmp++; if (busy[i] !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]); end
            n_cmp++; if (done[i] !== 1'b0) begin n_bad++; $display("FAIL reset_done[%0d]: got %b want 0", i, done[i]); end
            n_cmp++; if (data[i] !== 8'h00) begin n_bad++; $display("FAIL reset_data[%0d]: got %h want 00", i, data[i]); end
        end
        tick();
        @(negedge clk);
        n_cmp++; if (busy[1] !== 1'b0) begin n_bad++; $display("FAIL start_in_reset: busy got %b want 0", busy[1]); end
    endtask

    task automatic test_defaults();
        int m_len, m_done; bit seen; logic b;
        tick();
        m_len = rx[0].len(); m_done = done_cnt[0];
        pulse_start(0);
        @(negedge clk);
        n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL busy_rise: got %b want 1", busy[0]); end
        wait_done(0, 2000, seen, b);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL defaults_done: got %b want 1", seen); end
        n_cmp++; if (b !== 1'b0) begin n_bad++; $display("FAIL busy_at_done: got %b want 0", b); end
        repeat (3) @(negedge clk);
        n_cmp++; if (tail(0, m_len) != EXP0) begin n_bad++; $display("FAIL defaults_text: got '%s' want '%s'", vis(tail(0, m_len)), vis(EXP0)); end
        n_cmp++; if (done_cnt[0] - m_done !== 1) begin n_bad++; $display("FAIL defaults_done_count: got %0d want 1", done_cnt[0] - m_done); end
    endtask

    task automatic test_random_ready();
        int m_len, m_done, m_stall, m_err; bit seen;
        tick();
        m_len = rx[1].len(); m_done = done_cnt[1]; m_stall = stall_cnt[1]; m_err = stall_errs[1];
        pulse_start(1);
        seen = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            ready[1] = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done[1]) begin seen = 1'b1; break; end
            tick();
        end
        ready[1] = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL stall_done: got %b want 1", seen); end
        n_cmp++; if (tail(1, m_len) != EXP1) begin n_bad++; $display("FAIL stall_text: got '%s' want '%s'", vis(tail(1, m_len)), vis(EXP1)); end
        n_cmp++; if (stall_errs[1] - m_err !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d unstable stalls want 0", stall_errs[1] - m_err); end
        n_cmp++; if (!(stall_cnt[1] - m_stall > 0)) begin n_bad++; $display("FAIL stall_seen: got %0d stalls want >0", stall_cnt[1] - m_stall); end
        n_cmp++; if (done_cnt[1] - m_done !== 1) begin n_bad++; $display("FAIL stall_done_count: got %0d want 1", done_cnt[1] - m_done); end
    endtask

    task automatic test_extremes();
        int m_len, lat, gap; bit seen, nl; logic b;
        tick();
        m_len = rx[2].len();
        pulse_start(2);
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (valid[2]) begin lat = c; break; end
        end
        n_cmp++; if (lat < 1 || lat > 322) begin n_bad++; $display("FAIL first_latency: got %0d want 1..322", lat); end
        nl = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (valid[2] && ready[2] && data[2] == 8'h0A) begin nl = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (nl !== 1'b1) begin n_bad++; $display("FAIL first_newline: got %b want 1", nl); end
        gap = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (valid[2]) begin gap = c; break; end
        end
        n_cmp++; if (gap < 1 || gap > 322) begin n_bad++; $display("FAIL line_gap: got %0d want 1..322", gap); end
        wait_done(2, 2000, seen, b);
        repeat (3) @(negedge clk);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL extremes_done: got %b want 1", seen); end
        n_cmp++; if (tail(2, m_len) != EXP2) begin n_bad++; $display("FAIL extremes_text: got '%s' want '%s'", vis(tail(2, m_len)), vis(EXP2)); end
    endtask

    task automatic test_narrow();
        int m_len, m_done; bit seen; logic b;
        tick();
        m_len = rx[3].len(); m_done = done_cnt[3];
        pulse_start(3);
        wait_done(3, 1000, seen, b);
        repeat (3) @(negedge clk);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL narrow_done: got %b want 1", seen); end
        n_cmp++; if (tail(3, m_len) != EXP3) begin n_bad++; $display("FAIL narrow_text: got '%s' want '%s'", vis(tail(3, m_len)), vis(EXP3)); end
        n_cmp++; if (done_cnt[3] - m_done !== 1) begin n_bad++; $display("FAIL narrow_done_count: got %0d want 1", done_cnt[3] - m_done); end
    endtask

    task automatic test_back_to_back();
        int m_len, m_done; bit seen, seen2; logic b;
        tick();
        m_len = rx[0].len(); m_done = done_cnt[0];
        pulse_start(0);
        repeat (30) tick();
        pulse_start(0);
        repeat (30) tick();
        pulse_start(0);
        wait_done(0, 2000, seen, b);
        tick();
        pulse_start(0);
        @(negedge clk);
        n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL restart_busy: got %b want 1", busy[0]); end
        wait_done(0, 2000, seen2, b);
        repeat (3) @(negedge clk);
        n_cmp++; if (seen !== 1'b1 || seen2 !== 1'b1) begin n_bad++; $display("FAIL b2b_done: got %b%b want 11", seen, seen2); end
        n_cmp++; if (tail(0, m_len) != {EXP0, EXP0}) begin n_bad++; $display("FAIL b2b_text: got '%s' want '%s'", vis(tail(0, m_len)), vis({EXP0, EXP0})); end
        n_cmp++; if (done_cnt[0] - m_done !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt[0] - m_done); end
    endtask

    task automatic test_reset_mid();
        int m_len, m_done; bit found, seen; logic b;
        tick();
        pulse_start(0);
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (valid[0] && data[0] == 8'h39) begin found = 1'b1; break; end
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL reach_digit: got %b want 1", found); end
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        n_cmp++; if (valid[0] !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", valid[0]); end
        n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy[0]); end
        m_done = done_cnt[0];
        repeat (60) @(negedge clk);
        n_cmp++; if (done_cnt[0] - m_done !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", done_cnt[0] - m_done); end
        m_len = rx[0].len(); m_done = done_cnt[0];
        tick();
        pulse_start(0);
        wait_done(0, 2000, seen, b);
        repeat (3) @(negedge clk);
        n_cmp++; if (tail(0, m_len) != EXP0) begin n_bad++; $display("FAIL after_abort_text: got '%s' want '%s'", vis(tail(0, m_len)), vis(EXP0)); end
        n_cmp++; if (done_cnt[0] - m_done !== 1) begin n_bad++; $display("FAIL after_abort_done: got %0d want 1", done_cnt[0] - m_done); end
    endtask

    initial begin
        rst = 4'hF; start = 4'h0; ready = 4'hF;
        test_reset();
        test_defaults();
        test_random_ready();
        test_extremes();
        test_narrow();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
